// File: rtl/ita_step_sequencer_if.sv
// ita_step_sequencer_if
//   Tile command channel between the step sequencer and the ITA datapath.
//   master (sequencer): tile_valid, step, head, tile, requant_idx out;
//                       tile_ready, tile_done in.
//   slave  (datapath) : the mirror image.
//   Parameter HeadW is the width of the head index.
interface ita_step_sequencer_if #(
   parameter int unsigned HeadW = 1
) ();
   logic             tile_valid;
   logic             tile_ready;
   logic [2:0]       step;
   logic [HeadW-1:0] head;
   logic [31:0]      tile;
   logic [2:0]       requant_idx;
   logic             tile_done;

   modport master (
      output tile_valid, step, head, tile, requant_idx,
      input  tile_ready, tile_done
   );

   modport slave (
      input  tile_valid, step, head, tile, requant_idx,
      output tile_ready, tile_done
   );
endinterface

// File: rtl/ita_step_sequencer.sv
// ita_step_sequencer
//   Walks an ITA layer through its tile commands. Attention runs visit
//   Q,K,V,QK,AV,OW for every head; Feedforward runs issue the FF step only.
//   The number of issued-but-uncompleted tiles is capped at MaxOutstanding.
//
//   Ports
//     clk_i, rst_ni        clock, synchronous active-low reset
//     start_i              start request, config latched when accepted in IDLE
//     layer_i              0 = Attention, 1 = Feedforward
//     n_heads_i            heads to process (Attention)
//     lin_tiles_i          tiles per Q/K/V/OW/FF step
//     attn_tiles_i         tiles per QK/AV step
//     tile_if (master)     tile command channel, see ita_step_sequencer_if
//     busy_o, done_o       run in progress / one-cycle end-of-run pulse
//     perf_cycles_o        busy-cycle counter
//
//   Build option: define ITA_SEQ_PERF_EN to implement the busy-cycle counter;
//   otherwise perf_cycles_o is tied to zero.
//
//   state | meaning
//   IDLE  | waiting for start_i; also hosts the done_o cycle
//   ISSUE | presenting tile commands
//   DRAIN | all tiles issued, waiting for outstanding tiles to complete
module ita_step_sequencer #(
   parameter int unsigned H              = 1,
   parameter int unsigned MaxOutstanding = 8,
   localparam int unsigned HeadW  = (H > 1) ? $clog2(H) : 1,
   localparam int unsigned NHeadW = $clog2(H + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 layer_i,
   input  logic [NHeadW-1:0]    n_heads_i,
   input  logic [31:0]          lin_tiles_i,
   input  logic [31:0]          attn_tiles_i,
   ita_step_sequencer_if.master tile_if,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [31:0]          perf_cycles_o
);

   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

   localparam logic [2:0] StepIdle = 3'd0;
   localparam logic [2:0] StepQ    = 3'd1;
   localparam logic [2:0] StepQk   = 3'd4;
   localparam logic [2:0] StepAv   = 3'd5;
   localparam logic [2:0] StepOw   = 3'd6;
   localparam logic [2:0] StepFf   = 3'd7;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              layer_q, layer_d;
   logic [NHeadW-1:0] n_heads_q, n_heads_d;
   logic [31:0]       lin_q, lin_d;
   logic [31:0]       attn_q, attn_d;
   logic [2:0]        step_q, step_d;
   logic [HeadW-1:0]  head_q, head_d;
   logic [31:0]       tile_q, tile_d;
   logic [OutW-1:0]   out_q, out_d;
   logic              done_q, done_d;

   logic        tile_valid;
   logic        accept;
   logic        start_ok;
   logic        zero_cfg;
   logic        last_tile;
   logic        last_head;
   logic [31:0] step_tiles;

   // The done cycle is spent in IDLE but still counts as busy, so a start
   // arriving there is ignored.
   assign busy_o   = (state_q != StIdle) || done_q;
   assign done_o   = done_q;
   assign start_ok = (state_q == StIdle) && !done_q && start_i;

   assign zero_cfg = layer_i ? (lin_tiles_i == 32'd0)
                             : ((n_heads_i == '0) || (lin_tiles_i == 32'd0) ||
                                (attn_tiles_i == 32'd0));

   assign tile_valid = (state_q == StIssue) && (out_q < OutW'(MaxOutstanding));
   assign accept     = tile_valid && tile_if.tile_ready;

   assign step_tiles = ((step_q == StepQk) || (step_q == StepAv)) ? attn_q : lin_q;
   assign last_tile  = (tile_q == step_tiles - 32'd1);
   assign last_head  = ((NHeadW'(head_q) + NHeadW'(1)) == n_heads_q);

   // A completion with nothing outstanding is spurious and dropped.
   always_comb begin
      out_d = out_q;
      unique case ({accept, tile_if.tile_done && (out_q != '0)})
         2'b10:   out_d = out_q + OutW'(1);
         2'b01:   out_d = out_q - OutW'(1);
         default: out_d = out_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      layer_d   = layer_q;
      n_heads_d = n_heads_q;
      lin_d     = lin_q;
      attn_d    = attn_q;
      step_d    = step_q;
      head_d    = head_q;
      tile_d    = tile_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               layer_d   = layer_i;
               n_heads_d = n_heads_i;
               lin_d     = lin_tiles_i;
               attn_d    = attn_tiles_i;
               head_d    = '0;
               tile_d    = 32'd0;
               step_d    = layer_i ? StepFf : StepQ;
               if (zero_cfg) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end
         end

         StIssue: begin
            if (accept) begin
               if (!last_tile) begin
                  tile_d = tile_q + 32'd1;
               end else begin
                  tile_d = 32'd0;
                  if (layer_q) begin
                     state_d = StDrain;
                  end else if (step_q == StepOw) begin
                     if (last_head) begin
                        state_d = StDrain;
                     end else begin
                        head_d = head_q + HeadW'(1);
                        step_d = StepQ;
                     end
                  end else begin
                     step_d = step_q + 3'd1;
                  end
               end
            end
         end

         StDrain: begin
            if (out_d == '0) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         layer_q   <= 1'b0;
         n_heads_q <= '0;
         lin_q     <= 32'd0;
         attn_q    <= 32'd0;
         step_q    <= StepIdle;
         head_q    <= '0;
         tile_q    <= 32'd0;
         out_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         layer_q   <= layer_d;
         n_heads_q <= n_heads_d;
         lin_q     <= lin_d;
         attn_q    <= attn_d;
         step_q    <= step_d;
         head_q    <= head_d;
         tile_q    <= tile_d;
         out_q     <= out_d;
         done_q    <= done_d;
      end
   end

   // Command fields read as zero outside ISSUE so IDLE/DRAIN show step Idle.
   always_comb begin
      tile_if.tile_valid  = tile_valid;
      tile_if.step        = StepIdle;
      tile_if.head        = '0;
      tile_if.tile        = 32'd0;
      tile_if.requant_idx = 3'd0;
      if (state_q == StIssue) begin
         tile_if.step        = step_q;
         tile_if.head        = head_q;
         tile_if.tile        = tile_q;
         tile_if.requant_idx = (step_q == StepFf) ? 3'd0 : (step_q - 3'd1);
      end
   end

`ifdef ITA_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (start_ok) begin
         perf_d = 32'd0;
      end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_ita_step_sequencer.sv
module tb_ita_step_sequencer;
   localparam int unsigned H      = 2;
   localparam int unsigned MaxOut = 2;
   localparam int unsigned HeadW  = (H > 1) ? $clog2(H) : 1;
   localparam int unsigned NHeadW = $clog2(H + 1);

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              start_i;
   logic              layer_i;
   logic [NHeadW-1:0] n_heads_i;
   logic [31:0]       lin_tiles_i;
   logic [31:0]       attn_tiles_i;
   logic              busy_o;
   logic              done_o;
   logic [31:0]       perf_cycles_o;

   ita_step_sequencer_if #(.HeadW(HeadW)) tif ();

   ita_step_sequencer #(.H(H), .MaxOutstanding(MaxOut)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .layer_i       (layer_i),
      .n_heads_i     (n_heads_i),
      .lin_tiles_i   (lin_tiles_i),
      .attn_tiles_i  (attn_tiles_i),
      .tile_if       (tif),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .perf_cycles_o (perf_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          n_acc;
   int          n_done;
   bit          echo_done;
   bit          man_done;
   logic [63:0] exp_q[$];

`ifdef ITA_SEQ_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   function automatic logic [63:0] pk(input logic [2:0] s, input logic [2:0] r,
                                      input logic [7:0] h, input logic [31:0] t);
      return {18'd0, s, r, h, t};
   endfunction

   function automatic logic [63:0] cur();
      return pk(tif.step, tif.requant_idx, 8'(tif.head), tif.tile);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_attn(input int nh, input int lin, input int attn);
      for (int h = 0; h < nh; h++) begin
         for (int s = 1; s <= 6; s++) begin
            int cnt;
            cnt = (s == 4 || s == 5) ? attn : lin;
            for (int t = 0; t < cnt; t++)
               exp_q.push_back(pk(3'(s), 3'(s - 1), 8'(h), 32'(t)));
         end
      end
   endtask

   task automatic push_ff(input int lin);
      for (int t = 0; t < lin; t++) exp_q.push_back(pk(3'd7, 3'd0, 8'd0, 32'(t)));
   endtask

   // Observe the current cycle, cross one clock edge, then drive tile_done
   // for the new cycle (echo of the accept just made, or the manual level).
   task automatic tick();
      bit acc;
      acc = tif.tile_valid && tif.tile_ready;
      if (acc) begin
         n_acc++;
         if (exp_q.size() > 0) chk("accept", cur(), exp_q.pop_front());
      end
      if (done_o) n_done++;
      @(posedge clk_i);
      #1;
      tif.tile_done = echo_done ? acc : man_done;
   endtask

   task automatic do_start(input logic lay, input int nh, input int lin, input int attn);
      layer_i      = lay;
      n_heads_i    = NHeadW'(nh);
      lin_tiles_i  = 32'(lin);
      attn_tiles_i = 32'(attn);
      start_i      = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   task automatic clr();
      n_acc  = 0;
      n_done = 0;
      exp_q.delete();
   endtask

   initial begin
      rst_ni         = 1'b0;
      start_i        = 1'b0;
      layer_i        = 1'b0;
      n_heads_i      = '0;
      lin_tiles_i    = 32'd0;
      attn_tiles_i   = 32'd0;
      tif.tile_ready = 1'b0;
      tif.tile_done  = 1'b0;
      echo_done      = 1'b0;
      man_done       = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // reset state
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_valid", 64'(tif.tile_valid), 64'd0);
      chk("rst_cmd", cur(), pk(3'd0, 3'd0, 8'd0, 32'd0));
      chk("rst_perf", 64'(perf_cycles_o), 64'd0);

      // Attention, 2 heads, lin=2, attn=1, completion one cycle after accept
      clr();
      push_attn(2, 2, 1);
      echo_done      = 1'b1;
      tif.tile_ready = 1'b1;
      do_start(1'b0, 2, 2, 1);
      repeat (40) tick();
      chk("t1_accepts", 64'(n_acc), 64'd20);
      chk("t1_done", 64'(n_done), 64'd1);
      chk("t1_idle", 64'(busy_o), 64'd0);

      // Feedforward lin=3, no completions: cap at MaxOutstanding=2
      clr();
      push_ff(3);
      echo_done = 1'b0;
      man_done  = 1'b0;
      do_start(1'b1, 0, 3, 0);
      repeat (10) tick();
      chk("t2_capped_accepts", 64'(n_acc), 64'd2);
      chk("t2_valid_low", 64'(tif.tile_valid), 64'd0);
      chk("t2_busy", 64'(busy_o), 64'd1);
      man_done = 1'b1;
      repeat (3) tick();
      man_done = 1'b0;
      repeat (5) tick();
      chk("t2_accepts", 64'(n_acc), 64'd3);
      chk("t2_done", 64'(n_done), 64'd1);

      // ready low for 5 cycles mid-step, start_i pulsed while busy
      clr();
      push_ff(4);
      echo_done = 1'b1;
      do_start(1'b1, 0, 4, 0);
      tick();
      tif.tile_ready = 1'b0;
      layer_i        = 1'b0;
      n_heads_i      = NHeadW'(1);
      lin_tiles_i    = 32'd2;
      attn_tiles_i   = 32'd1;
      start_i        = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 64'(tif.tile_valid), 64'd1);
         chk("t3_hold_cmd", cur(), pk(3'd7, 3'd0, 8'd0, 32'd1));
         tick();
      end
      start_i        = 1'b0;
      tif.tile_ready = 1'b1;
      repeat (15) tick();
      chk("t3_accepts", 64'(n_acc), 64'd4);
      chk("t3_done", 64'(n_done), 64'd1);

      // accept and completion in the same cycle at outstanding=1
      clr();
      push_ff(4);
      echo_done = 1'b0;
      man_done  = 1'b1;
      do_start(1'b1, 0, 4, 0);
      tick();
      man_done = 1'b0;
      tick();
      tick();
      chk("t4_accepts", 64'(n_acc), 64'd3);
      chk("t4_valid_low", 64'(tif.tile_valid), 64'd0);
      man_done = 1'b1;
      repeat (3) tick();
      man_done = 1'b0;
      repeat (5) tick();
      chk("t4_total_accepts", 64'(n_acc), 64'd4);
      chk("t4_done", 64'(n_done), 64'd1);

      // zero tile count: done next cycle, start while busy ignored
      clr();
      do_start(1'b1, 0, 0, 0);
      chk("t5_done", 64'(done_o), 64'd1);
      chk("t5_busy", 64'(busy_o), 64'd1);
      chk("t5_valid", 64'(tif.tile_valid), 64'd0);
      do_start(1'b1, 0, 2, 0);
      chk("t5_ignored_busy", 64'(busy_o), 64'd0);
      chk("t5_ignored_done", 64'(done_o), 64'd0);
      chk("t5_perf", 64'(perf_cycles_o), PerfEn ? 64'd1 : 64'd0);
      do_start(1'b0, 0, 2, 1);
      chk("t5_zero_heads_done", 64'(done_o), 64'd1);
      chk("t5_zero_heads_step", 64'(tif.step), 64'd0);
      @(posedge clk_i);
      #1;

      // reset during DRAIN, then stray completions at outstanding=0
      clr();
      push_ff(1);
      echo_done = 1'b0;
      man_done  = 1'b0;
      do_start(1'b1, 0, 1, 0);
      tick();
      chk("t6_drain_busy", 64'(busy_o), 64'd1);
      chk("t6_drain_valid", 64'(tif.tile_valid), 64'd0);
      chk("t6_drain_step", 64'(tif.step), 64'd0);
      rst_ni   = 1'b0;
      man_done = 1'b1;
      tick();
      rst_ni = 1'b1;
      chk("t6_rst_busy", 64'(busy_o), 64'd0);
      chk("t6_rst_done", 64'(done_o), 64'd0);
      chk("t6_rst_perf", 64'(perf_cycles_o), 64'd0);
      repeat (3) tick();
      man_done = 1'b0;
      tick();
      chk("t6_no_done", 64'(n_done), 64'd0);
      clr();
      push_ff(1);
      echo_done = 1'b1;
      do_start(1'b1, 0, 1, 0);
      repeat (8) tick();
      chk("t6_accepts", 64'(n_acc), 64'd1);
      chk("t6_done", 64'(n_done), 64'd1);
      chk("t6_perf", 64'(perf_cycles_o), PerfEn ? 64'd3 : 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
